// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns for digits 0-9 and capture FSM states
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0011000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_e;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low segment pattern to BCD with blank/error flags
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       blank_o,
  output logic       err_o
);
  always_comb begin
    bcd_o = '0;
    blank_o = seg_i == SEG_BLANK;
    err_o = !blank_o;
    for (int i = 0; i < 10; i++)
      if (seg_i == SEG_DIGIT[i]) begin
        bcd_o = 4'(i);
        err_o = 1'b0;
      end
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: rebuilds scanned 7-segment digits into frames over valid/ready
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_i,
  input  logic [NDIG-1:0]   an_i,
  input  logic              frame_ready_i,
  output logic              frame_valid_o,
  output logic [4*NDIG-1:0] digits_o,
  output logic [NDIG-1:0]   blank_o,
  output logic [NDIG-1:0]   err_o
);
  localparam int CW = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 2);
  logic [6:0]        s_seg_q, p_seg_q;
  logic [NDIG-1:0]   s_an_q, p_an_q;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NDIG-1:0]   mask_q, mask_d, hit;
  logic [4*NDIG-1:0] sh_dig_q, sh_dig_d, dig_q;
  logic [NDIG-1:0]   sh_blank_q, sh_blank_d, blank_q;
  logic [NDIG-1:0]   sh_err_q, sh_err_d, err_q;
  logic              fv_q, fv_d;
  logic              same, an_ok, dec_blank, dec_err;
  logic [3:0]        dec_bcd;
  assign same  = {s_seg_q, s_an_q} == {p_seg_q, p_an_q};
  assign an_ok = $onehot(~s_an_q);
  // capture decodes the previous sample, which is the value that proved stable
  seg7_pattern_decode u_dec (
    .seg_i  (p_seg_q),
    .bcd_o  (dec_bcd),
    .blank_o(dec_blank),
    .err_o  (dec_err)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      IDLE:    state_d = an_ok ? SETTLE : IDLE;
      SETTLE:
        if (!an_ok) state_d = IDLE;
        else if (same) begin
          cnt_d = cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
          state_d = cnt_q == CNT_LAST ? CAPTURE : SETTLE;
        end
      CAPTURE: state_d = same ? HOLD : an_ok ? SETTLE : IDLE;
      HOLD:    state_d = same ? HOLD : an_ok ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign hit = state_q == CAPTURE ? ~p_an_q : '0;
  always_comb begin
    sh_dig_d = sh_dig_q;
    for (int i = 0; i < NDIG; i++)
      if (hit[i]) sh_dig_d[4*i +: 4] = dec_bcd;
    sh_blank_d = (sh_blank_q & ~hit) | (hit & {NDIG{dec_blank}});
    sh_err_d = (sh_err_q & ~hit) | (hit & {NDIG{dec_err}});
    // a capture coinciding with a transfer keeps its mask bit
    mask_d = (fv_q && frame_ready_i ? '0 : mask_q) | hit;
    fv_d = fv_q ? !frame_ready_i : &mask_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_seg_q <= '1;
      s_an_q <= '1;
      p_seg_q <= '1;
      p_an_q <= '1;
      state_q <= IDLE;
      cnt_q <= '0;
      mask_q <= '0;
      sh_dig_q <= '0;
      sh_blank_q <= '0;
      sh_err_q <= '0;
      dig_q <= '0;
      blank_q <= '0;
      err_q <= '0;
      fv_q <= 1'b0;
    end else begin
      s_seg_q <= seg_i;
      s_an_q <= an_i;
      p_seg_q <= s_seg_q;
      p_an_q <= s_an_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      sh_dig_q <= sh_dig_d;
      sh_blank_q <= sh_blank_d;
      sh_err_q <= sh_err_d;
      fv_q <= fv_d;
      if (!fv_q) begin
        dig_q <= sh_dig_d;
        blank_q <= sh_blank_d;
        err_q <= sh_err_d;
      end
    end
  assign frame_valid_o = fv_q;
  assign digits_o = dig_q;
  assign blank_o = blank_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed scans with a frame scoreboard and monitor
module tb_seg7_scan_capture;
  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0011000, OFF = 7'b1111111, BAD = 7'b0101010;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, NONE = 4'b1111;
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  b;
    logic [3:0]  e;
  } frame_t;
  logic clk = 1'b0, rst = 1'b1, ready = 1'b1, fv;
  logic [6:0] seg = OFF;
  logic [3:0] an = NONE, blank, err;
  logic [15:0] digits;
  frame_t q[$];
  frame_t f;
  int n_cmp = 0, n_err = 0;
  seg7_scan_capture #(.NDIG(4), .STABLE_CYC(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_i        (seg),
    .an_i         (an),
    .frame_ready_i(ready),
    .frame_valid_o(fv),
    .digits_o     (digits),
    .blank_o      (blank),
    .err_o        (err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    seg = s;
    an = a;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic scan(input logic [3:0][6:0] s, input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[i]) hold(s[i], ~(4'b0001 << i), 8);
    hold(OFF, NONE, 2);
  endtask
  task automatic expect_frame(input logic [15:0] d, input logic [3:0] b, input logic [3:0] e);
    q.push_back('{d: d, b: b, e: e});
  endtask
  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, 32'(q.size()), 32'd0);
  endtask
  always @(negedge clk)
    if (!rst && fv && ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_unexpected: got digits %h, expected no frame", digits);
      end else begin
        f = q.pop_front();
        check("frame_digits", 32'(digits), 32'(f.d));
        check("frame_blank", 32'(blank), 32'(f.b));
        check("frame_err", 32'(err), 32'(f.e));
      end
    end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(fv), 32'd0);
    check("reset_digits", 32'(digits), 32'd0);
    rst = 1'b0;
    // build mask 0101, then reset while digit 1 is settling
    scan({OFF, P3, OFF, P1}, 4'b0101);
    check("partial_digits", 32'(digits), 32'h0301);
    hold(P1, A1, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(fv), 32'd0);
    check("async_rst_digits", 32'(digits), 32'd0);
    check("async_rst_flags", 32'({blank, err}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    hold(P1, A1, 5);
    check("post_rst_early", 32'(digits), 32'h0000);
    hold(P1, A1, 1);
    check("post_rst_capture", 32'(digits), 32'h0010);
    hold(OFF, NONE, 2);
    expect_frame(16'h4321, 4'b0000, 4'b0000);
    scan({P4, P3, P2, P1}, 4'hf);
    drain("frame_4321");
    check("single_pulse", 32'(fv), 32'd0);
    hold(P5, A0, 3);
    hold(OFF, NONE, 6);
    check("short_hold", 32'(digits), 32'h4321);
    hold(P5, A0, 4);
    hold(OFF, NONE, 1);
    check("full_hold_early", 32'(digits), 32'h4321);
    hold(OFF, NONE, 1);
    check("full_hold_capture", 32'(digits), 32'h4325);
    hold(P7, 4'b1100, 8);
    hold(OFF, NONE, 2);
    check("two_anodes", 32'(digits), 32'h4325);
    expect_frame(16'h9005, 4'b0010, 4'b0100);
    scan({P9, BAD, OFF, OFF}, 4'b1110);
    drain("frame_decode");
    ready = 1'b0;
    expect_frame(16'h0865, 4'b0000, 4'b0000);
    scan({P0, P8, P6, P5}, 4'hf);
    check("bp_valid", 32'(fv), 32'd1);
    hold(P7, A0, 8);
    hold(OFF, NONE, 2);
    check("bp_frozen", 32'(digits), 32'h0865);
    check("bp_still_valid", 32'(fv), 32'd1);
    ready = 1'b1;
    drain("frame_bp");
    expect_frame(16'h0867, 4'b0000, 4'b0000);
    scan({P0, P8, P6, P7}, 4'hf);
    drain("frame_after_bp");
    ready = 1'b0;
    expect_frame(16'h4321, 4'b0000, 4'b0000);
    scan({P4, P3, P2, P1}, 4'hf);
    check("pend_valid", 32'(fv), 32'd1);
    // transfer lands on the same edge as the digit 2 capture
    hold(P9, A2, 5);
    ready = 1'b1;
    hold(P9, A2, 1);
    check("same_cycle_valid", 32'(fv), 32'd0);
    hold(P9, A2, 2);
    check("same_cycle_digit", 32'(digits), 32'h4921);
    expect_frame(16'h1957, 4'b0000, 4'b0000);
    scan({P1, OFF, P5, P7}, 4'b1011);
    drain("frame_no_rescan");
    ready = 1'b0;
    scan({P4, P3, P2, P1}, 4'hf);
    check("drop_pend_valid", 32'(fv), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("drop_async_valid", 32'(fv), 32'd0);
    check("drop_async_digits", 32'(digits), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;
    hold(OFF, NONE, 10);
    check("drop_no_frame", 32'(fv), 32'd0);
    drain("final_drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
